// File: rtl/snapshot_bram_writer.sv
// One-shot snapshot capture of a qualified stream into BRAM port A.
// Arm rising edge starts a capture (immediate or trigger-gated); arm low ends or aborts it.
module snapshot_bram_writer #(
   parameter int AW = 10,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          arm,
   input  logic          trig_ext_en,
   input  logic          trig,
   input  logic [AW:0]   cap_len,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   output logic          bram_we,
   output logic          bram_en_a,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_wr_data,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   words_written,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

   state_t        state_q, state_d;
   logic          arm_q;
   logic          arm_ok_q, arm_ok_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          arm_rise;
   logic          take;
   logic [AW:0]   eff_len;

   // arm_ok_q stays low until arm is seen low, so arm held high across reset is not an edge.
   assign arm_rise = arm & ~arm_q & arm_ok_q;
   assign eff_len  = ((cap_len == '0) || (cap_len > FULL_LEN)) ? FULL_LEN : cap_len;

   always_comb begin
      state_d  = state_q;
      arm_ok_d = arm_ok_q | ~arm;
      len_d    = len_q;
      cnt_d    = cnt_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      take     = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm_rise) begin
               len_d   = eff_len;
               cnt_d   = '0;
               state_d = trig_ext_en ? ARMED : CAPTURE;
            end
         end
         ARMED: begin
            if (!arm) begin
               state_d = IDLE;
            end else if (trig) begin
               state_d = CAPTURE;
               take    = din_valid;
            end
         end
         CAPTURE: begin
            if (!arm) state_d = IDLE;
            else      take    = din_valid;
         end
         DONE: begin
            if (!arm) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort has priority: a sample in the cycle arm drops is never written.
      if (take) begin
         we_d    = 1'b1;
         addr_d  = cnt_q[AW-1:0];
         wdata_d = din;
         cnt_d   = cnt_q + 1'b1;
         if ((cnt_q + 1'b1) == len_q) state_d = DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         arm_q    <= 1'b0;
         arm_ok_q <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         arm_q    <= arm;
         arm_ok_q <= arm_ok_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign bram_we       = we_q;
   assign bram_en_a     = we_q;
   assign bram_addr     = addr_q;
   assign bram_wr_data  = wdata_q;
   assign busy          = (state_q == ARMED) || (state_q == CAPTURE);
   assign done          = (state_q == DONE);
   assign words_written = cnt_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_snapshot_bram_writer.sv
// Bench for snapshot_bram_writer: directed scenarios plus randomized captures,
// scored against a word-list model of what each capture should commit.
module tb_snapshot_bram_writer;

   localparam int AW   = 10;
   localparam int DW   = 64;
   localparam int FULL = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0;
   logic          trig_ext_en = 1'b0;
   logic          trig = 1'b0;
   logic [AW:0]   cap_len = '0;
   logic [DW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic          bram_we;
   logic          bram_en_a;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wr_data;
   logic          busy;
   logic          done;
   logic [AW:0]   words_written;
   logic [1:0]    dbg_state;

   snapshot_bram_writer #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .trig_ext_en(trig_ext_en), .trig(trig),
      .cap_len(cap_len), .din(din), .din_valid(din_valid),
      .bram_we(bram_we), .bram_en_a(bram_en_a), .bram_addr(bram_addr),
      .bram_wr_data(bram_wr_data), .busy(busy), .done(done),
      .words_written(words_written), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [AW+DW-1:0] exp_q[$];

   // Capture model: phase of the current snapshot, its length and words taken so far.
   typedef enum int {P_IDLE, P_WAIT, P_RUN, P_FIN} phase_t;
   phase_t m_phase = P_IDLE;
   bit     m_prev_arm = 1'b0;
   bit     m_arm_ok = 1'b0;
   int     m_len = 0;
   int     m_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic accept();
      exp_q.push_back({m_cnt[AW-1:0], din});
      m_cnt++;
      if (m_cnt == m_len) m_phase = P_FIN;
   endtask

   // Evaluated on the inputs about to be sampled by the next rising edge.
   task automatic model_cycle();
      bit rise;
      rise = arm && !m_prev_arm && m_arm_ok;
      case (m_phase)
         P_IDLE: if (rise) begin
            m_len   = (cap_len == 0 || int'(cap_len) > FULL) ? FULL : int'(cap_len);
            m_cnt   = 0;
            m_phase = trig_ext_en ? P_WAIT : P_RUN;
         end
         P_WAIT: if (!arm) m_phase = P_IDLE;
                 else if (trig) begin
                    m_phase = P_RUN;
                    if (din_valid) accept();
                 end
         P_RUN:  if (!arm) m_phase = P_IDLE;
                 else if (din_valid) accept();
         P_FIN:  if (!arm) m_phase = P_IDLE;
         default: m_phase = P_IDLE;
      endcase
      if (!arm) m_arm_ok = 1'b1;
      m_prev_arm = arm;
   endtask

   task automatic check_outputs();
      logic [AW+DW-1:0] e;
      chk("en_eq_we", bram_en_a, bram_we);
      if (bram_we) begin
         chk("write_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", bram_addr, e[AW+DW-1:DW]);
            chk("wr_data", bram_wr_data, e[DW-1:0]);
         end
      end else begin
         chk("no_write_pending", exp_q.size(), 0);
      end
      chk("words_written", words_written, m_cnt);
      chk("done", done, m_phase == P_FIN);
      chk("busy", busy, (m_phase == P_WAIT) || (m_phase == P_RUN));
   endtask

   task automatic cycle();
      model_cycle();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_we", bram_we, 0);
      chk("rst_en", bram_en_a, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_data", bram_wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ww", words_written, 0);
      chk("rst_state", dbg_state, 0);
      exp_q.delete();
      m_phase = P_IDLE; m_prev_arm = 1'b0; m_arm_ok = 1'b0; m_cnt = 0; m_len = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle_gap(input int n);
      arm = 1'b0; trig = 1'b0; din_valid = 1'b0;
      repeat (n) cycle();
      chk("drained", exp_q.size(), 0);
   endtask

   initial begin
      int dropped;
      // Arm already high through reset must not start a capture.
      arm = 1'b1; trig_ext_en = 1'b0; cap_len = 4; din_valid = 1'b1;
      #2;
      do_reset();
      for (int k = 0; k < 6; k++) begin din = $urandom; cycle(); end
      chk("no_cap_after_rst", dbg_state, 0);
      idle_gap(2);

      // Immediate mode, din = cycle index; the edge-cycle sample is skipped.
      arm = 1'b1; trig_ext_en = 1'b0; cap_len = 4; din_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin din = k; cycle(); end
      chk("imm_done", done, 1);
      chk("imm_ww", words_written, 4);
      idle_gap(2);
      chk("imm_back_idle", dbg_state, 0);

      // External trigger: trig in IDLE ignored, then 0xA5 on the trigger cycle is word 0.
      trig = 1'b1; cycle(); trig = 1'b0;
      arm = 1'b1; trig_ext_en = 1'b1; cap_len = 3;
      repeat ($urandom_range(2, 6)) begin
         din = {$urandom, $urandom}; din_valid = 1'($urandom_range(0, 1)); cycle();
      end
      chk("ext_no_early_write", words_written, 0);
      trig = 1'b1; din = 64'hA5; din_valid = 1'b1; cycle();
      chk("ext_first_addr", bram_addr, 0);
      chk("ext_first_data", bram_wr_data, 64'hA5);
      trig = 1'b0;
      repeat (6) begin din = {$urandom, $urandom}; din_valid = 1'($urandom_range(0, 1)); cycle(); end
      idle_gap(2);

      // Alternating valid with length 2.
      arm = 1'b1; trig_ext_en = 1'b0; cap_len = 2; din_valid = 1'b0; cycle();
      for (int k = 0; k < 6; k++) begin
         din = {$urandom, $urandom}; din_valid = (k % 2 == 0); cycle();
      end
      chk("alt_ww", words_written, 2);
      idle_gap(2);

      // cap_len = 0 and an oversize length both clamp to the full depth.
      for (int pass = 0; pass < 2; pass++) begin
         arm = 1'b1; trig_ext_en = 1'b0; cap_len = (pass == 0) ? 0 : 2047;
         din_valid = 1'b0; cycle();
         repeat (FULL + FULL / 4) begin
            din = {$urandom, $urandom}; din_valid = ($urandom_range(0, 7) != 0); cycle();
         end
         chk("full_done", done, 1);
         chk("full_ww", words_written, FULL);
         idle_gap(2);
      end

      // Abort after 5 of 8 words keeps the partial count.
      arm = 1'b1; trig_ext_en = 1'b0; cap_len = 8; din_valid = 1'b0; cycle();
      din_valid = 1'b1;
      repeat (5) begin din = {$urandom, $urandom}; cycle(); end
      arm = 1'b0; din = {$urandom, $urandom}; cycle();
      repeat (3) cycle();
      chk("abort_state", dbg_state, 0);
      chk("abort_done", done, 0);
      chk("abort_ww", words_written, 5);
      idle_gap(1);

      // Reset mid-capture with arm held: nothing until arm goes low then high.
      arm = 1'b1; trig_ext_en = 1'b0; cap_len = 8; din_valid = 1'b1; cycle();
      repeat (3) begin din = {$urandom, $urandom}; cycle(); end
      #3;
      do_reset();
      repeat (8) begin din = {$urandom, $urandom}; cycle(); end
      chk("rst_mid_no_cap", words_written, 0);
      arm = 1'b0; cycle();
      arm = 1'b1; cap_len = 3;
      repeat (6) begin din = {$urandom, $urandom}; cycle(); end
      chk("rst_mid_recap", words_written, 3);
      idle_gap(2);

      // Randomized captures: cap_len and trig wiggle throughout, occasional aborts.
      for (int run = 0; run < 30; run++) begin
         arm = 1'b1; trig_ext_en = 1'($urandom_range(0, 1));
         cap_len = $urandom_range(1, 12); dropped = 0;
         for (int k = 0; k < 25; k++) begin
            din = {$urandom, $urandom};
            din_valid = 1'($urandom_range(0, 1));
            trig = ($urandom_range(0, 4) == 0);
            if (k > 0) cap_len = $urandom_range(0, 2047);
            if (!dropped && $urandom_range(0, 40) == 0) dropped = 1;
            arm = !dropped;
            cycle();
         end
         trig = 1'b0;
         idle_gap(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
